// File: rtl/bus_xfer_pkg.sv
// Shared definitions for the bus transfer scheduler.
// Holds the FSM state encoding, the register count and index width,
// the requester (owner) encoding and a one-hot decode helper.
package bus_xfer_pkg;

  localparam int NREG  = 4;
  localparam int IDX_W = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRIVE   = 3'd1,
    LOAD    = 3'd2,
    RELEASE = 3'd3,
    ERR     = 3'd4
  } state_t;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_t;

  // Turn a register index into the enable pattern that selects it.
  function automatic logic [NREG-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NREG-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/bus_xfer_sched_rr_arb2.sv
// Two-way round-robin arbiter used by the bus transfer scheduler.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   req[1:0]  - request lines, bit 0 = requester A, bit 1 = requester B
//   advance   - the current grant is being taken; rotate priority
//   gnt[1:0]  - one-hot grant, or zero when nobody requests
// Priority starts at A and, after every taken grant, moves to the
// requester that did not win.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  import bus_xfer_pkg::*;

  owner_t pri_q;

  // Only a true tie consults the priority; a lone requester always wins.
  always_comb begin
    gnt = '0;
    if (req == 2'b11) begin
      gnt = (pri_q == OWNER_B) ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

  // Hand priority to the loser of the grant that is being consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      pri_q <= OWNER_A;
    end else if (advance && (gnt != 2'b00)) begin
      pri_q <= gnt[0] ? OWNER_B : OWNER_A;
    end
  end

endmodule

// File: rtl/bus_xfer_sched.sv
// Bus transfer scheduler: serialises register-to-register moves over one
// shared tri-state bus for two requesters (A and B).
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   req_x_valid/src/dst           - request for a move src -> dst (x = a, b)
//   req_x_ack                     - one-cycle pulse, request accepted
//   req_x_done                    - one-cycle pulse, move completed
//   reg_oe[NREG-1:0]              - drives register i onto the bus
//   reg_en[NREG-1:0]              - loads register i from the bus
//   busy                          - scheduler is not idle
//   xfer_err                      - one-cycle pulse, accepted request had src == dst
// A move runs IDLE -> DRIVE -> LOAD -> RELEASE; RELEASE leaves the bus
// undriven for a cycle so two different drivers never overlap.
module bus_xfer_sched #(
  parameter int NREG = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_a_valid,
  input  logic [1:0]      req_a_src,
  input  logic [1:0]      req_a_dst,
  output logic            req_a_ack,
  output logic            req_a_done,
  input  logic            req_b_valid,
  input  logic [1:0]      req_b_src,
  input  logic [1:0]      req_b_dst,
  output logic            req_b_ack,
  output logic            req_b_done,
  output logic [NREG-1:0] reg_oe,
  output logic [NREG-1:0] reg_en,
  output logic            busy,
  output logic            xfer_err
);
  import bus_xfer_pkg::*;

  state_t          state_q, state_d;
  owner_t          owner_q, owner_d;
  logic [1:0]      src_q, src_d;
  logic [1:0]      dst_q, dst_d;
  logic [1:0]      gnt;
  logic            advance;
  logic [NREG-1:0] oe_d, en_d;
  logic            ack_a_d, ack_b_d, done_a_d, done_b_d, busy_d, err_d;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({req_b_valid, req_a_valid}),
    .advance (advance),
    .gnt     (gnt)
  );

  // Next-state logic, then the outputs that belong to the next state so
  // they can be registered and appear exactly in the cycle of that state.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    src_d    = src_q;
    dst_d    = dst_q;
    advance  = 1'b0;
    oe_d     = '0;
    en_d     = '0;
    ack_a_d  = 1'b0;
    ack_b_d  = 1'b0;
    done_a_d = 1'b0;
    done_b_d = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          advance = 1'b1;
          owner_d = gnt[1] ? OWNER_B : OWNER_A;
          src_d   = gnt[1] ? req_b_src : req_a_src;
          dst_d   = gnt[1] ? req_b_dst : req_a_dst;
          state_d = (src_d == dst_d) ? ERR : DRIVE;
        end
      end
      DRIVE:   state_d = LOAD;
      LOAD:    state_d = RELEASE;
      RELEASE: state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      DRIVE: begin
        oe_d    = onehot(src_d);
        ack_a_d = (owner_d == OWNER_A);
        ack_b_d = (owner_d == OWNER_B);
      end
      LOAD: begin
        oe_d = onehot(src_d);
        en_d = onehot(dst_d);
      end
      RELEASE: begin
        done_a_d = (owner_d == OWNER_A);
        done_b_d = (owner_d == OWNER_B);
      end
      ERR: begin
        ack_a_d = (owner_d == OWNER_A);
        ack_b_d = (owner_d == OWNER_B);
        err_d   = 1'b1;
      end
      default: begin
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, captured request and all outputs; reset aborts any transfer
  // in flight so no done or load enable can follow it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWNER_A;
      src_q      <= '0;
      dst_q      <= '0;
      reg_oe     <= '0;
      reg_en     <= '0;
      req_a_ack  <= 1'b0;
      req_b_ack  <= 1'b0;
      req_a_done <= 1'b0;
      req_b_done <= 1'b0;
      busy       <= 1'b0;
      xfer_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      reg_oe     <= oe_d;
      reg_en     <= en_d;
      req_a_ack  <= ack_a_d;
      req_b_ack  <= ack_b_d;
      req_a_done <= done_a_d;
      req_b_done <= done_b_d;
      busy       <= busy_d;
      xfer_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_bus_xfer_sched.sv
// Testbench for bus_xfer_sched: a vector table for the single-transfer and
// contention scenarios, hand-written error and reset-in-LOAD sequences,
// and randomized traffic compared with a transaction-level model that
// also tracks the contents of four 4-bit registers hung on the bus.
module tb_bus_xfer_sched;

  typedef struct packed {
    logic       ackA;
    logic       doneA;
    logic       ackB;
    logic       doneB;
    logic [3:0] oe;
    logic [3:0] en;
    logic       busy;
    logic       err;
  } obs_t;

  typedef struct {
    logic       rst;
    logic       aV;
    logic [1:0] aS;
    logic [1:0] aD;
    logic       bV;
    logic [1:0] bS;
    logic [1:0] bD;
    obs_t       exp;
    logic       dChk;
    logic [1:0] dIdx;
    logic [3:0] dVal;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       aValid, bValid;
  logic [1:0] aSrc, aDst, bSrc, bDst;
  logic       ackA, doneA, ackB, doneB;
  logic [3:0] regOe, regEn;
  logic       busyS, errS;
  obs_t       obsNow;
  logic [3:0] bank [4];
  logic [3:0] busVal;
  vec_t       vecs [$];
  int         total = 0;
  int         bad   = 0;

  bus_xfer_sched #(.NREG(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_a_valid (aValid),
    .req_a_src   (aSrc),
    .req_a_dst   (aDst),
    .req_a_ack   (ackA),
    .req_a_done  (doneA),
    .req_b_valid (bValid),
    .req_b_src   (bSrc),
    .req_b_dst   (bDst),
    .req_b_ack   (ackB),
    .req_b_done  (doneB),
    .reg_oe      (regOe),
    .reg_en      (regEn),
    .busy        (busyS),
    .xfer_err    (errS)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  assign obsNow = {ackA, doneA, ackB, doneB, regOe, regEn, busyS, errS};

  // Shared bus: whichever register is output-enabled drives it.
  always_comb begin
    busVal = '0;
    for (int i = 0; i < 4; i++) begin
      if (regOe[i]) busVal = busVal | bank[i];
    end
  end

  // Four real registers; reset restores a known set of contents.
  always @(posedge clk) begin
    if (rst) begin
      bank[0] <= 4'h1;
      bank[1] <= 4'hA;
      bank[2] <= 4'h5;
      bank[3] <= 4'h7;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (regEn[i]) bank[i] <= busVal;
      end
    end
  end

  // Safety net so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, wanted finish");
    $fatal(1, "[TB] watchdog");
  end

  function automatic obs_t mkObs(input logic aa, input logic da, input logic ab, input logic db,
                                 input logic [3:0] oe, input logic [3:0] en,
                                 input logic bz, input logic er);
    obs_t o;
    o.ackA = aa; o.doneA = da; o.ackB = ab; o.doneB = db;
    o.oe = oe; o.en = en; o.busy = bz; o.err = er;
    return o;
  endfunction

  task automatic addVec(input logic r, input logic av, input logic [1:0] as1, input logic [1:0] ad1,
                        input logic bv, input logic [1:0] bs1, input logic [1:0] bd1,
                        input obs_t e, input logic dc, input logic [1:0] di, input logic [3:0] dv);
    vec_t v;
    v.rst = r; v.aV = av; v.aS = as1; v.aD = ad1;
    v.bV = bv; v.bS = bs1; v.bD = bd1;
    v.exp = e; v.dChk = dc; v.dIdx = di; v.dVal = dv;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic r, input logic av, input logic [1:0] as1, input logic [1:0] ad1,
                               input logic bv, input logic [1:0] bs1, input logic [1:0] bd1);
    rst = r; aValid = av; aSrc = as1; aDst = ad1;
    bValid = bv; bSrc = bs1; bDst = bd1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input obs_t e);
    total++;
    if (obsNow !== e) begin
      bad++;
      $display("[TB] FAIL %s: got ackA=%b doneA=%b ackB=%b doneB=%b oe=%b en=%b busy=%b err=%b, want ackA=%b doneA=%b ackB=%b doneB=%b oe=%b en=%b busy=%b err=%b",
               name, obsNow.ackA, obsNow.doneA, obsNow.ackB, obsNow.doneB, obsNow.oe, obsNow.en,
               obsNow.busy, obsNow.err, e.ackA, e.doneA, e.ackB, e.doneB, e.oe, e.en, e.busy, e.err);
    end
  endtask

  task automatic checkData(input string name, input logic [1:0] idx, input logic [3:0] val);
    total++;
    if (bank[idx] !== val) begin
      bad++;
      $display("[TB] FAIL %s: register %0d got %h, want %h", name, idx, bank[idx], val);
    end
  endtask

  // Randomized traffic against a transaction-level model: the model only
  // knows when a transfer was granted, its owner/src/dst and whether it is
  // an error, and derives each cycle's outputs from the cycle offset.
  task automatic runModel(input string tag, input int cycles, input bit both);
    int         t = 0;
    int         gAt = 0;
    int         freeAt = 0;
    bit         hasX = 1'b0;
    bit         xErr = 1'b0;
    bit         xOwn = 1'b0;
    logic [1:0] xSrc = 2'd0;
    logic [1:0] xDst = 2'd0;
    bit         prio = 1'b0;
    bit         aP = 1'b0;
    bit         bP = 1'b0;
    int         aDrop = 0;
    int         bDrop = 0;
    logic [1:0] rAS = 2'd0, rAD = 2'd0, rBS = 2'd0, rBD = 2'd0;
    logic [3:0] mRegs [4] = '{4'h1, 4'hA, 4'h5, 4'h7};
    obs_t       e;

    for (int c = 0; c < cycles; c++) begin
      if (aDrop > 0) begin
        aDrop--;
        if (aDrop == 0) aP = 1'b0;
      end
      if (bDrop > 0) begin
        bDrop--;
        if (bDrop == 0) bP = 1'b0;
      end
      if (!aP) begin
        if (both || $urandom_range(0, 2) == 0) begin
          aP = 1'b1;
          rAS = 2'($urandom_range(0, 3));
          rAD = 2'($urandom_range(0, 3));
        end
      end else if (!both && aDrop == 0 && $urandom_range(0, 19) == 0) begin
        aP = 1'b0;
      end
      if (!bP) begin
        if (both || $urandom_range(0, 2) == 0) begin
          bP = 1'b1;
          rBS = 2'($urandom_range(0, 3));
          rBD = 2'($urandom_range(0, 3));
        end
      end else if (!both && bDrop == 0 && $urandom_range(0, 19) == 0) begin
        bP = 1'b0;
      end
      applyStimulus(1'b0, aP, rAS, rAD, bP, rBS, rBD);

      if (hasX && !xErr && t == gAt + 2) mRegs[xDst] = mRegs[xSrc];

      if (t >= freeAt && ((aP && aDrop == 0) || (bP && bDrop == 0))) begin
        if (aP && aDrop == 0 && bP && bDrop == 0) xOwn = prio;
        else xOwn = (bP && bDrop == 0);
        xSrc   = xOwn ? rBS : rAS;
        xDst   = xOwn ? rBD : rAD;
        xErr   = (xSrc == xDst);
        hasX   = 1'b1;
        gAt    = t;
        freeAt = t + (xErr ? 2 : 4);
        prio   = !xOwn;
        if (xOwn) bDrop = 2;
        else aDrop = 2;
      end

      tick();
      t++;

      e = '0;
      if (hasX && t < freeAt) begin
        e.busy = 1'b1;
        case (t - gAt)
          1: begin
            if (xOwn) e.ackB = 1'b1;
            else e.ackA = 1'b1;
            if (xErr) e.err = 1'b1;
            else e.oe = 4'(4'b0001 << xSrc);
          end
          2: begin
            e.oe = 4'(4'b0001 << xSrc);
            e.en = 4'(4'b0001 << xDst);
          end
          3: begin
            if (xOwn) e.doneB = 1'b1;
            else e.doneA = 1'b1;
          end
          default: begin
          end
        endcase
      end
      checkOutput($sformatf("%s_c%0d", tag, t), e);
    end

    for (int i = 0; i < 4; i++) begin
      checkData($sformatf("%s_data", tag), 2'(i), mRegs[i]);
    end
  endtask

  // Main sequence: vector table, directed corner cases, randomized runs.
  initial begin
    obs_t z;
    z = mkObs(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    applyStimulus(1'b1, 0, 0, 0, 0, 0, 0);
    tick();

    addVec(1, 0, 0, 0, 0, 0, 0, z, 0, 0, 0);
    addVec(0, 1, 1, 3, 0, 0, 0, mkObs(1, 0, 0, 0, 4'b0010, 4'b0000, 1, 0), 0, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 0, mkObs(0, 0, 0, 0, 4'b0010, 4'b1000, 1, 0), 0, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 0, mkObs(0, 1, 0, 0, 4'b0000, 4'b0000, 1, 0), 0, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 0, z, 1, 3, 4'hA);
    addVec(1, 0, 0, 0, 0, 0, 0, z, 0, 0, 0);
    addVec(0, 1, 0, 1, 1, 2, 3, mkObs(1, 0, 0, 0, 4'b0001, 4'b0000, 1, 0), 0, 0, 0);
    addVec(0, 0, 0, 0, 1, 2, 3, mkObs(0, 0, 0, 0, 4'b0001, 4'b0010, 1, 0), 0, 0, 0);
    addVec(0, 0, 0, 0, 1, 2, 3, mkObs(0, 1, 0, 0, 4'b0000, 4'b0000, 1, 0), 0, 0, 0);
    addVec(0, 0, 0, 0, 1, 2, 3, z, 1, 1, 4'h1);
    addVec(0, 0, 0, 0, 1, 2, 3, mkObs(0, 0, 1, 0, 4'b0100, 4'b0000, 1, 0), 0, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 0, mkObs(0, 0, 0, 0, 4'b0100, 4'b1000, 1, 0), 0, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 0, mkObs(0, 0, 0, 1, 4'b0000, 4'b0000, 1, 0), 0, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 0, z, 1, 3, 4'h5);
    addVec(0, 1, 3, 0, 1, 1, 2, mkObs(1, 0, 0, 0, 4'b1000, 4'b0000, 1, 0), 0, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 0, mkObs(0, 0, 0, 0, 4'b1000, 4'b0001, 1, 0), 0, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 0, mkObs(0, 1, 0, 0, 4'b0000, 4'b0000, 1, 0), 0, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 0, z, 1, 0, 4'h5);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].aV, vecs[i].aS, vecs[i].aD,
                    vecs[i].bV, vecs[i].bS, vecs[i].bD);
      tick();
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
      if (vecs[i].dChk) checkData($sformatf("vec%0d_data", i), vecs[i].dIdx, vecs[i].dVal);
    end

    $display("[TB] error request sequence");
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("err_reset", z);
    applyStimulus(0, 0, 0, 0, 1, 2, 2);
    tick();
    checkOutput("err_ack", mkObs(0, 0, 1, 0, 4'b0000, 4'b0000, 1, 1));
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("err_idle%0d", i), z);
    end

    $display("[TB] reset during LOAD sequence");
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("rl_reset", z);
    applyStimulus(0, 1, 1, 2, 0, 0, 0);
    tick();
    checkOutput("rl_drive", mkObs(1, 0, 0, 0, 4'b0010, 4'b0000, 1, 0));
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("rl_load", mkObs(0, 0, 0, 0, 4'b0010, 4'b0100, 1, 0));
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("rl_abort", z);
    applyStimulus(0, 1, 0, 3, 1, 1, 2);
    tick();
    checkOutput("rl_prioA", mkObs(1, 0, 0, 0, 4'b0001, 4'b0000, 1, 0));
    applyStimulus(0, 0, 0, 0, 1, 1, 2);
    tick();
    checkOutput("rl_loadA", mkObs(0, 0, 0, 0, 4'b0001, 4'b1000, 1, 0));
    tick();
    checkOutput("rl_doneA", mkObs(0, 1, 0, 0, 4'b0000, 4'b0000, 1, 0));
    tick();
    checkOutput("rl_idle", z);
    tick();
    checkOutput("rl_driveB", mkObs(0, 0, 1, 0, 4'b0010, 4'b0000, 1, 0));
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("rl_loadB", mkObs(0, 0, 0, 0, 4'b0010, 4'b0100, 1, 0));
    tick();
    checkOutput("rl_doneB", mkObs(0, 0, 0, 1, 4'b0000, 4'b0000, 1, 0));

    $display("[TB] fairness run, both requesters always valid");
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    tick();
    runModel("fair", 34, 1'b1);

    $display("[TB] randomized run");
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    tick();
    runModel("rand", 600, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
